prog_counter: RTL and testbench

- Parametrised successor of the team's free-running 8-bit counter.
- Adds configurable width, programmable modulo limit, up/down direction, a prescaler, wrap/saturate/one-shot modes, a parallel-load handshake, a terminal-count pulse and a sticky overflow flag.
- Instantiated inside a tt_um_* top; uo_out/uio mapping is done by the wrapper.

---
 rtl/prog_counter_pkg.sv | 16 +
 rtl/prog_counter_prescaler.sv | 28 ++
 rtl/prog_counter.sv | 104 ++++++++++
 tb/tb_prog_counter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/prog_counter_pkg.sv
// Shared types for the programmable counter: count-mode encoding and FSM states.
package prog_counter_pkg;

   typedef enum logic [1:0] {
      MODE_WRAP    = 2'b00,
      MODE_SAT     = 2'b01,
      MODE_ONESHOT = 2'b10,
      MODE_RSVD    = 2'b11
   } mode_e;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_DONE = 1'b1
   } state_e;

endpackage

// File: rtl/prog_counter_prescaler.sv
// Enable-gated prescaler: emits one tick every prescale+1 enabled cycles.
module prog_counter_prescaler #(
   parameter int PRESCALE_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ena,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  sync_clr,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] pcnt;

   // Lowering prescale below pcnt lets pcnt run through all-ones before matching again.
   assign tick = ena && (pcnt == prescale);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt <= '0;
      end else if (sync_clr) begin
         pcnt <= '0;
      end else if (ena) begin
         pcnt <= tick ? '0 : pcnt + PRESCALE_W'(1);
      end
   end

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with modulo limit, prescaler, wrap/saturate/one-shot
// modes, parallel load, terminal-count pulse and sticky overflow flag.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_RUN  | counting on prescaler ticks
//   ST_DONE | one-shot finished; ticks ignored until start, load or clear
module prog_counter
   import prog_counter_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int PRESCALE_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ena,
   input  logic [1:0]            mode,
   input  logic                  dir,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic [WIDTH-1:0]      limit,
   input  logic                  clear,
   input  logic                  start,
   input  logic                  load_valid,
   input  logic [WIDTH-1:0]      load_data,
   output logic                  load_ready,
   input  logic                  ovf_clr,
   output logic [WIDTH-1:0]      count,
   output logic                  tc_pulse,
   output logic                  ovf_sticky,
   output logic                  running
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d, count_step;
   logic             tc_q, tc_d, ovf_q;
   logic             tick, load_fire, terminal, step_term;
   mode_e            mode_m;

   assign mode_m     = mode_e'(mode);
   assign load_ready = !clear;
   assign load_fire  = load_valid && load_ready;

   prog_counter_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .prescale (prescale),
      .sync_clr (clear || load_fire),
      .tick     (tick)
   );

   // Up uses >= so a limit lowered below the current count still terminates.
   assign terminal   = dir ? (count_q >= limit) : (count_q == '0);
   assign count_step = dir ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
   assign step_term  = dir ? (count_step >= limit) : (count_step == '0);

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      tc_d    = 1'b0;
      if (clear) begin
         state_d = ST_RUN;
         count_d = '0;
      end else if (load_fire) begin
         state_d = ST_RUN;
         count_d = (load_data > limit) ? limit : load_data;
      end else if (state_q == ST_DONE) begin
         if (start) state_d = ST_RUN;
      end else if (tick) begin
         if (!terminal) begin
            count_d = count_step;
            // Saturate reports the arrival at the end value, not the held ticks after it.
            if (mode_m == MODE_SAT) tc_d = step_term;
         end else if (mode_m == MODE_ONESHOT) begin
            state_d = ST_DONE;
            tc_d    = 1'b1;
         end else if (mode_m != MODE_SAT) begin
            count_d = dir ? '0 : limit;
            tc_d    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         count_q <= '0;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         tc_q    <= tc_d;
         if (tc_d)         ovf_q <= 1'b1;
         else if (ovf_clr) ovf_q <= 1'b0;
      end
   end

   assign count      = count_q;
   assign tc_pulse   = tc_q;
   assign ovf_sticky = ovf_q;
   assign running    = (state_q == ST_RUN);

endmodule

// File: tb/tb_prog_counter.sv
// Directed bench for prog_counter (WIDTH=8, PRESCALE_W=8) with hand-computed expectations.
module tb_prog_counter;

   logic       clk = 1'b0;
   logic       rst_n, ena, dir, clear, start, load_valid, ovf_clr;
   logic [1:0] mode;
   logic [7:0] prescale, limit, load_data;
   logic       load_ready, tc_pulse, ovf_sticky, running;
   logic [7:0] count;

   int n_tests = 0;
   int n_fail  = 0;
   int n_tc    = 0;

   always #5 clk = ~clk;

   prog_counter #(.WIDTH(8), .PRESCALE_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .mode       (mode),
      .dir        (dir),
      .prescale   (prescale),
      .limit      (limit),
      .clear      (clear),
      .start      (start),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .ovf_clr    (ovf_clr),
      .count      (count),
      .tc_pulse   (tc_pulse),
      .ovf_sticky (ovf_sticky),
      .running    (running)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges and settle 1ns past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; ena = 1'b1; mode = 2'b00; dir = 1'b1;
      prescale = 8'd0; limit = 8'd255; clear = 1'b0; start = 1'b0;
      load_valid = 1'b0; load_data = 8'd0; ovf_clr = 1'b0;

      #12;
      chk("rst_count", count, 0);
      chk("rst_tc", tc_pulse, 0);
      chk("rst_ovf", ovf_sticky, 0);
      chk("rst_running", running, 1);
      chk("rst_load_ready", load_ready, 1);

      // legacy free-run
      @(negedge clk); rst_n = 1'b1;
      step(255);
      chk("free_255", count, 255);
      chk("free_255_tc", tc_pulse, 0);
      step(1);
      chk("free_wrap", count, 0);
      chk("free_wrap_tc", tc_pulse, 1);
      chk("free_wrap_ovf", ovf_sticky, 1);
      step(1);
      chk("free_after", count, 1);
      chk("free_after_tc", tc_pulse, 0);

      // prescale 3, modulo 10
      prescale = 8'd3; limit = 8'd9; clear = 1'b1; ovf_clr = 1'b1;
      step(1);
      chk("pre_clear", count, 0);
      chk("pre_ovf_clr", ovf_sticky, 0);
      clear = 1'b0; ovf_clr = 1'b0;
      step(4);  chk("pre_e4", count, 1);
      step(3);  chk("pre_e7", count, 1);
      step(1);  chk("pre_e8", count, 2);
      step(28); chk("pre_e36", count, 9);
      chk("pre_e36_tc", tc_pulse, 0);
      step(4);  chk("pre_wrap", count, 0);
      chk("pre_wrap_tc", tc_pulse, 1);
      step(1);  chk("pre_wrap_tc_low", tc_pulse, 0);
      step(27); chk("pre_at7", count, 7);
      limit = 8'd4;
      step(3);  chk("pre_low_hold", count, 7);
      chk("pre_low_hold_tc", tc_pulse, 0);
      step(1);  chk("pre_low_wrap", count, 0);
      chk("pre_low_wrap_tc", tc_pulse, 1);

      // saturate down from 5
      prescale = 8'd0; limit = 8'd9; mode = 2'b01; dir = 1'b0;
      load_valid = 1'b1; load_data = 8'd5; ovf_clr = 1'b1;
      step(1);
      chk("sat_load", count, 5);
      chk("sat_load_tc", tc_pulse, 0);
      chk("sat_load_ovf", ovf_sticky, 0);
      load_valid = 1'b0; ovf_clr = 1'b0;
      for (int i = 4; i >= 1; i--) begin
         step(1);
         chk("sat_step", count, i);
         if (tc_pulse) n_tc++;
      end
      ovf_clr = 1'b1;
      step(1);
      chk("sat_zero", count, 0);
      chk("sat_zero_tc", tc_pulse, 1);
      chk("sat_ovf_set_wins", ovf_sticky, 1);
      if (tc_pulse) n_tc++;
      ovf_clr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk("sat_hold", count, 0);
         if (tc_pulse) n_tc++;
      end
      chk("sat_tc_once", n_tc, 1);

      // one-shot to 3
      mode = 2'b10; dir = 1'b1; limit = 8'd3; clear = 1'b1;
      step(1);
      clear = 1'b0;
      chk("os_clear", count, 0);
      for (int i = 1; i <= 3; i++) begin
         step(1);
         chk("os_step", count, i);
         chk("os_running", running, 1);
      end
      step(1);
      chk("os_done_count", count, 3);
      chk("os_done_running", running, 0);
      chk("os_done_tc", tc_pulse, 1);
      step(2);
      chk("os_ignore_count", count, 3);
      chk("os_ignore_tc", tc_pulse, 0);
      mode = 2'b00; start = 1'b1;
      step(1);
      start = 1'b0;
      chk("os_start_running", running, 1);
      chk("os_start_count", count, 3);
      step(1);
      chk("os_rearm_wrap", count, 0);
      chk("os_rearm_tc", tc_pulse, 1);

      // clear > load > tick
      limit = 8'd255; clear = 1'b1; load_valid = 1'b1; load_data = 8'h20;
      #1;
      chk("prio_load_ready", load_ready, 0);
      step(1);
      chk("prio_count", count, 0);
      clear = 1'b0; limit = 8'h10;
      #1;
      chk("prio_load_ready_back", load_ready, 1);
      step(1);
      chk("load_clamp", count, 8'h10);
      chk("load_no_tc", tc_pulse, 0);
      load_valid = 1'b0;

      // asynchronous reset mid-count
      limit = 8'd255; load_valid = 1'b1; load_data = 8'h28;
      step(1);
      load_valid = 1'b0;
      step(2);
      chk("ar_count_pre", count, 8'h2A);
      chk("ar_ovf_pre", ovf_sticky, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_count", count, 0);
      chk("ar_ovf", ovf_sticky, 0);
      chk("ar_running", running, 1);
      rst_n = 1'b1;
      step(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
